sample_assembler: RTL and testbench
===================================

SAMPLE_ASSEMBLER -- requirements
Module: sample_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: idle cycles mid-sample before a partial sample is discarded; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data  input  8  incoming byte, valid while data_rdy is high.
REQ-005 data_rdy  input  1  upstream byte available; held until acknowledged.
REQ-006 data_ack  output  1  combinational; byte on data consumed at this clock edge.
REQ-007 sample  output  48  assembled sample, first byte received in [47:40], sixth in [7:0].
REQ-008 sample_rdy  output  1  registered; sample holds a complete, unconsumed word.
REQ-009 sample_ack  input  1  downstream consumes sample on any edge where sample_rdy and sample_ack are both high.
REQ-010 timeout_err  output  1  registered one-cycle pulse; partial sample discarded.

Function
REQ-011 The block SHALL implement two states: COLLECT (accepting bytes) and PRESENT (holding a complete sample).
REQ-012 data_ack SHALL equal (state==COLLECT) and data_rdy and not reset; it SHALL be low in PRESENT.
REQ-013 On each edge with data_ack high, byte byte_idx SHALL be written to sample[47-8*byte_idx -: 8] and byte_idx (3 bits, 0..5) SHALL increment.
REQ-014 On an accepted byte with byte_idx==5, byte_idx SHALL return to 0, state SHALL become PRESENT, and sample_rdy SHALL be high the next cycle.
REQ-015 Back-to-back bytes SHALL be accepted one per cycle; minimum sample period is 7 cycles (6 accepts + 1 handshake cycle).
REQ-016 In PRESENT, sample SHALL be stable; on an edge with sample_ack high, sample_rdy SHALL drop and state SHALL return to COLLECT the next cycle.
REQ-017 sample_ack SHALL be ignored while sample_rdy is low.
REQ-018 byte_idx values 6 and 7 SHALL be unreachable; if reached, the block SHALL return to byte_idx 0 in COLLECT.
REQ-019 The data value presented when data_rdy is low SHALL have no effect on sample.

Reset
REQ-020 While reset is high: state=COLLECT, byte_idx=0, sample=48'h0, sample_rdy=0, timeout_err=0, timeout counter=0, data_ack=0.
REQ-021 Reset asserted mid-sample or during PRESENT SHALL discard the partial or pending sample without asserting timeout_err.

Configuration
REQ-022 With macro SAMPLE_ASSEMBLER_TIMEOUT_EN defined, a 16-bit idle counter SHALL increment each COLLECT cycle with byte_idx!=0 and data_rdy low, and SHALL clear on any accepted byte.
REQ-023 With SAMPLE_ASSEMBLER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 and data_rdy is still low, byte_idx SHALL clear to 0, the counter SHALL clear, and timeout_err SHALL pulse for one cycle.
REQ-024 If data_rdy is high on the expiring cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-025 Without SAMPLE_ASSEMBLER_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied 0, and partial samples SHALL wait indefinitely.

Structure
REQ-026 Shared package sample_pkg SHALL hold SAMPLE_W=48, BYTES_PER_SAMPLE=6, and the assembler state encoding; the serializing counterpart SHALL use the same constants.
REQ-027 The idle counter SHALL be a sub-module, idle_timer (enable, clear, expire output), instantiated only under SAMPLE_ASSEMBLER_TIMEOUT_EN.

Verification
REQ-028 Bytes 01,23,45,67,89,AB with data_rdy held high -> six consecutive data_ack cycles, sample=48'h0123456789AB, sample_rdy high on the 7th cycle.
REQ-029 Sample ready, sample_ack held low 20 cycles with data_rdy high -> data_ack low throughout, sample stable; sample_ack pulse -> sample_rdy low next cycle, next byte accepted the cycle after.
REQ-030 Reset after 3 bytes, then 6 bytes 11..66 -> sample=48'h112233445566, timeout_err never asserted.
REQ-031 TIMEOUT_EN, TIMEOUT_CYCLES=8, 2 bytes then data_rdy low -> timeout_err single pulse after 8 idle cycles; next 6 bytes form a correct sample.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=8, data_rdy returns on the expiring cycle -> byte accepted, no timeout_err, sample completes.
REQ-033 Serializer-to-assembler loopback, 1000 random 48-bit samples with random sample_ack stalls -> every sample received in order and bit-exact.

Source files
------------

// File: rtl/sample_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_pkg
//  Description : Shared constants and state encoding for the byte-to-sample
//                assembler and its serializing counterpart.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_pkg;

    localparam int SAMPLE_W         = 48;
    localparam int BYTES_PER_SAMPLE = 6;
    localparam int BYTE_W           = 8;
    localparam int IDX_W            = 3;
    localparam int TIMER_W          = 16;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } asm_state_t;

    // Map the unreachable byte indices (6, 7) back onto slot 0 so the
    // assembler always recovers to a clean start of sample.
    function automatic logic [IDX_W-1:0] sanitize_idx(input logic [IDX_W-1:0] idx);
        return (idx < IDX_W'(BYTES_PER_SAMPLE)) ? idx : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_assembler_if
//  Description : Byte-in / sample-out handshake bundle. The master side is the
//                byte source plus the sample consumer; the slave side is the
//                assembler itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_assembler_if;
    import sample_pkg::*;

    logic [BYTE_W-1:0]   data;
    logic                data_rdy;
    logic                data_ack;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_rdy;
    logic                sample_ack;
    logic                timeout_err;

    modport master (
        output data, data_rdy, sample_ack,
        input  data_ack, sample, sample_rdy, timeout_err
    );

    modport slave (
        input  data, data_rdy, sample_ack,
        output data_ack, sample, sample_rdy, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/sample_assembler_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : idle_timer
//  Description : 16-bit idle counter. Counts enabled cycles, clears on demand,
//                and flags expiry on the enabled cycle where the count has
//                reached LIMIT-1. Expiry also clears the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module idle_timer
    import sample_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable_i,
    input  wire logic clear_i,
    output logic      expire_o
);

    localparam logic [TIMER_W-1:0] c_LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] count_q;

    assign expire_o = enable_i && (count_q == c_LAST);

    // Idle cycle counter; any accepted byte or expiry restarts it
    always_ff @(posedge clk) begin
        if (reset || clear_i || expire_o) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : sample_assembler
//  Description : Collects six bytes (first byte in the MSBs) into a 48-bit
//                sample and holds it until downstream acknowledges.
//                Optional mid-sample idle timeout, enabled by defining the
//                macro SAMPLE_ASSEMBLER_TIMEOUT_EN; without it timeout_err is
//                constant 0 and partial samples wait indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_assembler
    import sample_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sample_assembler_if.slave  bus
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("sample_assembler: TIMEOUT_CYCLES must lie in 2..65535");
        end
    endgenerate

    asm_state_t          state_q;
    logic [IDX_W-1:0]    byte_idx_q;
    logic [IDX_W-1:0]    byte_idx_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic                sample_rdy_q;
    logic                timeout_err_q;

    logic                w_accept;
    logic                w_expire;
    logic [IDX_W-1:0]    w_byte_slot;
    logic [5:0]          w_byte_lsb;

    // Byte is taken whenever we are collecting and upstream offers one
    assign w_accept    = (state_q == ST_COLLECT) && bus.data_rdy && !reset;
    assign w_byte_slot = sanitize_idx(byte_idx_q);
    assign byte_idx_d  = w_byte_slot + IDX_W'(1);
    assign w_byte_lsb  = 6'(SAMPLE_W - BYTE_W) - {w_byte_slot, 3'b000};

`ifdef SAMPLE_ASSEMBLER_TIMEOUT_EN
    logic w_timer_en;

    // Only a partially filled sample with no byte on offer counts as idle
    assign w_timer_en = (state_q == ST_COLLECT) && (byte_idx_q != '0) && !bus.data_rdy;

    idle_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (w_timer_en),
        .clear_i  (w_accept),
        .expire_o (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Collect bytes into the sample register, then hold it until acknowledged
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_COLLECT;
            byte_idx_q    <= '0;
            sample_q      <= '0;
            sample_rdy_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= w_expire;
            case (state_q)
                ST_COLLECT: begin
                    if (w_accept) begin
                        sample_q[w_byte_lsb +: BYTE_W] <= bus.data;
                        if (w_byte_slot == IDX_W'(BYTES_PER_SAMPLE - 1)) begin
                            byte_idx_q   <= '0;
                            state_q      <= ST_PRESENT;
                            sample_rdy_q <= 1'b1;
                        end else begin
                            byte_idx_q <= byte_idx_d;
                        end
                    end else if (w_expire || (byte_idx_q != w_byte_slot)) begin
                        byte_idx_q <= '0;
                    end
                end
                ST_PRESENT: begin
                    if (bus.sample_ack && sample_rdy_q) begin
                        sample_rdy_q <= 1'b0;
                        state_q      <= ST_COLLECT;
                    end
                end
                default: begin
                    state_q      <= ST_COLLECT;
                    byte_idx_q   <= '0;
                    sample_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_ack    = w_accept;
    assign bus.sample      = sample_q;
    assign bus.sample_rdy  = sample_rdy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_assembler
//  Description : Directed and loopback test of sample_assembler with a
//                queue-based scoreboard of expected samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_assembler;
    import sample_pkg::*;

    localparam int TB_TIMEOUT = 8;
    localparam int LB_SAMPLES = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sample_assembler_if bus();

    sample_assembler #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_tmo    = 0;
    int cyc      = 0;

    logic [SAMPLE_W-1:0] sb_q[$];
    logic [SAMPLE_W-1:0] acc_val;
    int                  acc_cnt;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.timeout_err === 1'b1) n_tmo++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference assembler: shift bytes in, first byte ends in the MSBs
    function automatic void model_accept(input logic [7:0] b);
        acc_val = {acc_val[SAMPLE_W-BYTE_W-1:0], b};
        acc_cnt++;
        if (acc_cnt == BYTES_PER_SAMPLE) begin
            sb_q.push_back(acc_val);
            acc_cnt = 0;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.data     = b;
        bus.data_rdy = 1'b1;
        #1;
        while (bus.data_ack !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        chk("data_ack", bus.data_ack, 1);
        step();
        model_accept(b);
        bus.data_rdy = 1'b0;
        bus.data     = 8'($urandom);
    endtask

    task automatic consume(input string tag);
        int waited;
        logic [SAMPLE_W-1:0] exp;
        waited = 0;
        while (bus.sample_rdy !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        chk({tag, "_rdy"}, bus.sample_rdy, 1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        bus.sample_ack = 1'b1;
        #1;
        chk({tag, "_sample"}, bus.sample, exp);
        step();
        bus.sample_ack = 1'b0;
        chk({tag, "_drop"}, bus.sample_rdy, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.data_rdy = 1'b1;
        bus.data     = 8'h5A;
        #1;
        chk("rst_ack_low", bus.data_ack, 0);
        step();
        step();
        bus.data_rdy = 1'b0;
        reset        = 1'b0;
        acc_cnt      = 0;
        sb_q.delete();
    endtask

    logic [7:0]          b28 [6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    logic [SAMPLE_W-1:0] tx_q[$];
    logic [SAMPLE_W-1:0] lb_word;
    logic [63:0]         rnd;
    logic                lb_acc;
    int                  rx, byte_i, gap, cyc_n, cyc_start;

    initial begin
        bus.data       = '0;
        bus.data_rdy   = 1'b0;
        bus.sample_ack = 1'b0;
        acc_cnt        = 0;
        acc_val        = '0;

        // Reset values, with a byte on offer to show data_ack is held low
        step();
        step();
        bus.data_rdy = 1'b1;
        #1;
        chk("rst_data_ack", bus.data_ack, 0);
        chk("rst_sample", bus.sample, 0);
        chk("rst_sample_rdy", bus.sample_rdy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        bus.data_rdy = 1'b0;
        step();
        reset = 1'b0;

        // Back-to-back bytes form 0123456789AB, ready on the 7th cycle
        cyc_start = cyc;
        foreach (b28[i]) send_byte(b28[i]);
        chk("t28_cycles", cyc - cyc_start, 6);
        chk("t28_rdy_7th", bus.sample_rdy, 1);
        chk("t28_sample", bus.sample, 48'h0123456789AB);

        // Held sample: no bytes taken, sample stable, then handshake
        bus.data     = 8'hCD;
        bus.data_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t29_ack_low", bus.data_ack, 0);
            chk("t29_stable", bus.sample, 48'h0123456789AB);
            step();
        end
        bus.sample_ack = 1'b1;
        #1;
        chk("t29_pop", bus.sample, (sb_q.size() > 0) ? sb_q.pop_front() : '1);
        step();
        bus.sample_ack = 1'b0;
        chk("t29_rdy_drop", bus.sample_rdy, 0);
        #1;
        chk("t29_ack_next", bus.data_ack, 1);
        step();
        model_accept(8'hCD);
        bus.data_rdy = 1'b0;

        // Reset after three bytes discards them silently
        send_byte(8'hEE);
        send_byte(8'hFF);
        do_reset();
        chk("t30_rst_rdy", bus.sample_rdy, 0);
        chk("t30_rst_sample", bus.sample, 0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11));
        consume("t30");
        chk("t30_no_tmo", n_tmo, 0);

        // Reset while a complete sample is pending
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
        chk("tp_rdy", bus.sample_rdy, 1);
        do_reset();
        chk("tp_rst_rdy", bus.sample_rdy, 0);
        chk("tp_rst_sample", bus.sample, 0);
        chk("tp_no_tmo", n_tmo, 0);

`ifdef SAMPLE_ASSEMBLER_TIMEOUT_EN
        // Two bytes then silence: one timeout pulse after 8 idle cycles
        send_byte(8'hC1);
        send_byte(8'hC2);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step();
        chk("t31_pre", bus.timeout_err, 0);
        step();
        chk("t31_pulse", bus.timeout_err, 1);
        step();
        chk("t31_one_cycle", bus.timeout_err, 0);
        chk("t31_count", n_tmo, 1);
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hD1 + i));
        consume("t31");

        // Byte arrives on the expiring cycle: accepted, no timeout
        send_byte(8'hE1);
        send_byte(8'hE2);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step();
        send_byte(8'hE3);
        chk("t32_no_pulse", bus.timeout_err, 0);
        send_byte(8'hE4);
        send_byte(8'hE5);
        send_byte(8'hE6);
        consume("t32");
        chk("t32_count", n_tmo, 1);
`else
        // Without the timeout a partial sample waits indefinitely
        send_byte(8'hC1);
        send_byte(8'hC2);
        repeat (40) step();
        chk("nt_no_pulse", bus.timeout_err, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC3 + i));
        consume("nt");
        chk("nt_count", n_tmo, 0);
`endif

        // Serializer loopback with random gaps, junk data and ack stalls
        sb_q.delete();
        for (int i = 0; i < LB_SAMPLES; i++) begin
            rnd = {$urandom, $urandom};
            tx_q.push_back(rnd[SAMPLE_W-1:0]);
        end
        rx     = 0;
        byte_i = 0;
        gap    = 0;
        cyc_n  = 0;
        bus.data_rdy = 1'b0;
        while (rx < LB_SAMPLES && cyc_n < 40000) begin
            if (!bus.data_rdy) begin
                if (tx_q.size() > 0 && (gap >= 3 || $urandom_range(0, 1) == 1)) begin
                    lb_word      = tx_q[0];
                    bus.data     = lb_word[SAMPLE_W-1-BYTE_W*byte_i -: BYTE_W];
                    bus.data_rdy = 1'b1;
                    gap          = 0;
                end else begin
                    bus.data = 8'($urandom);
                    gap++;
                end
            end
            bus.sample_ack = ($urandom_range(0, 2) == 0);
            #1;
            lb_acc = bus.data_ack;
            if (bus.sample_rdy === 1'b1 && bus.sample_ack) begin
                chk("lb_sample", bus.sample, (sb_q.size() > 0) ? sb_q.pop_front() : '1);
                rx++;
            end
            step();
            cyc_n++;
            if (lb_acc) begin
                byte_i++;
                if (byte_i == BYTES_PER_SAMPLE) begin
                    byte_i = 0;
                    sb_q.push_back(tx_q.pop_front());
                end
                bus.data_rdy = 1'b0;
            end
        end
        bus.sample_ack = 1'b0;
        chk("lb_received", rx, LB_SAMPLES);
        chk("lb_no_tmo_change", bus.timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire
